// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCK
    } arbState_t;

    typedef enum logic [1:0] {
        NONE,
        CPU,
        EXT
    } owner_t;

    // Ext requester is word-wide only.
    localparam logic [2:0] FUNCT3_SW = 3'b010;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and data memory.
// master: requesters plus memory read data; slave: the arbiter.
interface dmem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [2:0]    cpu_funct3;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          ext_req;
    logic          ext_we;
    logic          ext_lock;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [DW-1:0] ext_rdata;

    logic          mem_we;
    logic [2:0]    mem_funct3;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_we, mem_funct3, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_we, mem_funct3, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module arb_sat_counter #(
    parameter int unsigned Width = 4,
    parameter int unsigned Max   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [Width-1:0] count,
    output logic             sat
);
    localparam logic [Width-1:0] MaxVal = Width'(Max);

    logic [Width-1:0] countQ;
    logic [Width-1:0] countD;

    assign sat   = (countQ >= MaxVal);
    assign count = countQ;

    // Next count: clear, else increment until the ceiling.
    always_comb begin
        countD = countQ;
        if (clr) begin
            countD = '0;
        end else if (inc && !sat) begin
            countD = countQ + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one memory port between the CPU load/store
// path and an external word-wide requester, with ext locked bursts of bounded
// length and bounded CPU starvation. Read data is registered per side.
// Optional feature macro: DMEM_ARB_PERF_EN enables the 16-bit saturating
// stall/ext-grant performance counters; otherwise those outputs are tied to 0.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MAX_STARVE = 4,
    parameter int unsigned BURST_MAX  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_port_arbiter_if.slave   bus,
    output logic [15:0]          perf_stall_cnt,
    output logic [15:0]          perf_ext_cnt
);
    arbState_t stateQ;
    arbState_t stateD;
    owner_t    owner;

    logic          cpuGnt;
    logic          extGnt;
    logic          cpuStall;
    logic          starveInc;
    logic          starveClr;
    logic          starveSat;
    logic [3:0]    starveCnt;
    logic          burstInc;
    logic          burstClr;
    logic          burstSat;
    logic [7:0]    burstCnt;
    logic          cpuRvalidQ;
    logic          extRvalidQ;
    logic [DW-1:0] cpuRdataQ;
    logic [DW-1:0] extRdataQ;

    // Pick the owner of this cycle's access and the next arbitration state.
    always_comb begin
        stateD   = stateQ;
        owner    = NONE;
        burstInc = 1'b0;
        burstClr = 1'b0;
        if (!reset) begin
            unique case (stateQ)
                IDLE: begin
                    if (bus.ext_req && bus.cpu_req) begin
                        owner = starveSat ? CPU : EXT;
                    end else if (bus.ext_req) begin
                        owner = EXT;
                    end else if (bus.cpu_req) begin
                        owner = CPU;
                    end
                    if (owner == EXT && bus.ext_lock) begin
                        stateD   = LOCK;
                        burstInc = 1'b1;
                    end
                end
                LOCK: begin
                    stateD   = IDLE;
                    burstClr = 1'b1;
                    if (burstSat) begin
                        // Forced release: the port goes back to the CPU first.
                        if (bus.cpu_req) begin
                            owner = CPU;
                        end
                    end else if (bus.ext_req && bus.ext_lock) begin
                        owner    = EXT;
                        stateD   = LOCK;
                        burstClr = 1'b0;
                        burstInc = 1'b1;
                    end else if (bus.ext_req) begin
                        owner = EXT;
                    end else if (bus.cpu_req) begin
                        owner = CPU;
                    end
                end
                default: begin
                    stateD = IDLE;
                end
            endcase
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    assign cpuGnt   = (owner == CPU);
    assign extGnt   = (owner == EXT);
    assign cpuStall = bus.cpu_req & ~cpuGnt;

    // Starvation only accrues while idle-arbitrating; it is frozen inside a lock.
    assign starveClr = cpuGnt | ~bus.cpu_req;
    assign starveInc = (stateQ == IDLE) & cpuStall;

    arb_sat_counter #(
        .Width (4),
        .Max   (MAX_STARVE)
    ) uStarve (
        .clk   (clk),
        .reset (reset),
        .inc   (starveInc),
        .clr   (starveClr),
        .count (starveCnt),
        .sat   (starveSat)
    );

    arb_sat_counter #(
        .Width (8),
        .Max   (BURST_MAX)
    ) uBurst (
        .clk   (clk),
        .reset (reset),
        .inc   (burstInc),
        .clr   (burstClr),
        .count (burstCnt),
        .sat   (burstSat)
    );

    // Memory port mux driven by the current owner.
    always_comb begin
        bus.mem_we     = 1'b0;
        bus.mem_funct3 = 3'b000;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        case (owner)
            CPU: begin
                bus.mem_we     = bus.cpu_we;
                bus.mem_funct3 = bus.cpu_funct3;
                bus.mem_addr   = bus.cpu_addr;
                bus.mem_wdata  = bus.cpu_wdata;
            end
            EXT: begin
                bus.mem_we     = bus.ext_we;
                bus.mem_funct3 = FUNCT3_SW;
                bus.mem_addr   = bus.ext_addr;
                bus.mem_wdata  = bus.ext_wdata;
            end
            default: ;
        endcase
    end

    // Capture load data for the granted side; rvalid is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpuRvalidQ <= 1'b0;
            extRvalidQ <= 1'b0;
            cpuRdataQ  <= '0;
            extRdataQ  <= '0;
        end else begin
            cpuRvalidQ <= cpuGnt & ~bus.cpu_we;
            extRvalidQ <= extGnt & ~bus.ext_we;
            if (cpuGnt && !bus.cpu_we) begin
                cpuRdataQ <= bus.mem_rdata;
            end
            if (extGnt && !bus.ext_we) begin
                extRdataQ <= bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_gnt    = cpuGnt;
    assign bus.cpu_stall  = cpuStall;
    assign bus.cpu_rvalid = cpuRvalidQ;
    assign bus.cpu_rdata  = cpuRdataQ;
    assign bus.ext_gnt    = extGnt;
    assign bus.ext_rvalid = extRvalidQ;
    assign bus.ext_rdata  = extRdataQ;

`ifdef DMEM_ARB_PERF_EN
    logic perfStallSat;
    logic perfExtSat;

    arb_sat_counter #(
        .Width (16),
        .Max   (16'hFFFF)
    ) uPerfStall (
        .clk   (clk),
        .reset (reset),
        .inc   (cpuStall),
        .clr   (1'b0),
        .count (perf_stall_cnt),
        .sat   (perfStallSat)
    );

    arb_sat_counter #(
        .Width (16),
        .Max   (16'hFFFF)
    ) uPerfExt (
        .clk   (clk),
        .reset (reset),
        .inc   (extGnt),
        .clr   (1'b0),
        .count (perf_ext_cnt),
        .sat   (perfExtSat)
    );

    logic unusedSignals;
    assign unusedSignals = ^{starveCnt, burstCnt, perfStallSat, perfExtSat};
`else
    assign perf_stall_cnt = 16'h0000;
    assign perf_ext_cnt   = 16'h0000;

    logic unusedSignals;
    assign unusedSignals = ^{starveCnt, burstCnt};
`endif
endmodule
